avalon_body_fetch: RTL
======================

# avalon_body_fetch

Avalon-MM read master that, once per video frame, fetches every body's scaled radius and x/y/z position from a memory-mapped body table and publishes them as one coherent snapshot for the ball renderers. It is the initiator counterpart to the body register file slave: it issues the single-word reads that the slave answers. The block sits between the Avalon fabric and the VGA drawing logic. It double-buffers the fetched values so a snapshot never changes partway through a frame.

## Interface
- NUM_BODIES, 4, number of bodies fetched per frame (1–16)
- BASE_ADDR, 32'h0, byte address of body 0 radius word
- TIMEOUT, 255, maximum cycles to wait for readdatavalid per word (≥2)

- CLK  in  1  system clock, 50 MHz
- RESET  in  1  reset, synchronous, active-high
- VGA_VS  in  1  vertical sync, active-low, asynchronous to CLK
- ENABLE  in  1  permits new frame fetches
- AVL_M_ADDR  out  32  read byte address
- AVL_M_READ  out  1  read request
- AVL_M_BYTE_EN  out  4  4'b1111 while AVL_M_READ is high, else 4'b0000
- AVL_M_WAITREQUEST  in  1  fabric stall
- AVL_M_READDATAVALID  in  1  read data valid
- AVL_M_READDATA  in  32  read data
- BODY_DATA  out  128*NUM_BODIES  committed snapshot; body b field f (0 radius, 1 x, 2 y, 3 z) at bits [(4b+f)*32 +: 32]
- FRAME_DONE  out  1  one-cycle pulse when a new snapshot commits
- FETCH_ERR  out  1  most recent fetch aborted on timeout
- BUSY  out  1  high in any state except IDLE

## Operation
- VGA_VS passes through a 2-flop synchronizer, then a third flop. Trigger = delayed & ~synchronized, i.e. a falling edge.
- Word index w = 4b+f runs from 0 to 4*NUM_BODIES-1. AVL_M_ADDR = BASE_ADDR + 4*w. The address counter is 6 bits and has no wrap within a frame.
- FSM states:
  - IDLE: trigger & ENABLE -> REQ, with w=0 and the timeout counter cleared. Otherwise stay.
  - REQ: AVL_M_READ=1 and AVL_M_ADDR held stable. When AVL_M_WAITREQUEST=0 the read is accepted -> WAIT_DATA. The block has no limit on waitrequest stall length.
  - WAIT_DATA: AVL_M_READ=0.
    - On readdatavalid, the shadow word w captures AVL_M_READDATA. If w is the last word -> COMMIT; else w+1 -> REQ.
    - The timeout counter increments each cycle. When it reaches TIMEOUT without valid -> IDLE, FETCH_ERR<=1, shadow discarded, BODY_DATA unchanged.
  - COMMIT: BODY_DATA<=shadow, FRAME_DONE<=1 (registered, one cycle), FETCH_ERR<=0 -> IDLE.
- The block keeps at most one read outstanding at any time.
- readdatavalid outside WAIT_DATA is ignored. A late response after a timeout therefore never reaches the shadow.
- A trigger while BUSY is dropped. No queueing occurs and no FRAME_DONE is issued for it.
- ENABLE falling mid-fetch does not abort; the current frame completes.
- Reset, including mid-fetch: the next edge forces IDLE.
  - AVL_M_READ=0, AVL_M_BYTE_EN=0, AVL_M_ADDR=BASE_ADDR.
  - BODY_DATA=0, shadow=0, FRAME_DONE=0, FETCH_ERR=0, BUSY=0.
  - Synchronizer flops reset to 1, so reset release with VGA_VS already low produces no trigger.

## Timing
- VGA_VS first sampled low at edge k: trigger is high after edge k+2, and AVL_M_READ is high after edge k+3.
- Zero waitrequest, latency-1 data: 2 cycles per word (REQ, WAIT_DATA), plus 1 COMMIT cycle.
  - NUM_BODIES=4: first READ to FRAME_DONE = 33 cycles.
- FRAME_DONE and new BODY_DATA appear in the same cycle. BODY_DATA changes only at COMMIT.
- Each cycle of waitrequest stall adds 1 cycle; each cycle of extra read latency adds 1 cycle.
- Timeout fires on the TIMEOUT-th WAIT_DATA cycle without valid. FETCH_ERR rises the cycle after.

## Test plan
- Reset, memory word w = 32'h100+w, NUM_BODIES=4, one VGA_VS fall:
  - Required: 16 reads at addresses 0x00–0x3C; FRAME_DONE once; BODY_DATA[31:0]=0x100 and BODY_DATA[511:480]=0x10F; done 33 cycles after first READ.
- Waitrequest held 5 cycles on word 3:
  - Required: AVL_M_ADDR=0x0C stable throughout; the word is read once; FRAME_DONE arrives 5 cycles later than baseline.
- No readdatavalid on word 7, TIMEOUT=255:
  - Required: FETCH_ERR=1 after 255 cycles; BODY_DATA keeps the prior snapshot.
  - Then a late valid is injected in IDLE: shadow unchanged.
  - The next good frame clears FETCH_ERR.
- Second VGA_VS fall injected mid-fetch:
  - Required: no restart; exactly one FRAME_DONE.
- RESET asserted during word 9 REQ:
  - Required: next cycle AVL_M_READ=0, BODY_DATA=0, BUSY=0.
  - The following frame fetches all 16 words correctly.
- ENABLE=0 at VGA_VS fall:
  - Required: no read issued.
  - Setting ENABLE=0 mid-fetch still completes the frame.

Source files
------------

// File: rtl/avalon_body_fetch.sv
// Avalon-MM read master that fetches every body's radius and x/y/z once per frame
// and publishes them as a double-buffered snapshot for the renderers.
module avalon_body_fetch #(
  parameter int unsigned NUM_BODIES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      VGA_VS,
  input  logic                      ENABLE,
  output logic [31:0]               AVL_M_ADDR,
  output logic                      AVL_M_READ,
  output logic [3:0]                AVL_M_BYTE_EN,
  input  logic                      AVL_M_WAITREQUEST,
  input  logic                      AVL_M_READDATAVALID,
  input  logic [31:0]               AVL_M_READDATA,
  output logic [128*NUM_BODIES-1:0] BODY_DATA,
  output logic                      FRAME_DONE,
  output logic                      FETCH_ERR,
  output logic                      BUSY
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 4 * NUM_BODIES;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    COMMIT
  } state_t;

  state_t             state_q, state_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;
  logic [TMO_W-1:0]   tmo_q, tmo_nx;
  logic               shadow_we;
  logic               commit;
  logic               err_set;

  logic               vs_meta_q, vs_sync_q, vs_dly_q;
  logic               post_rst_q, armed_q, trig_q;

  logic [WORD_W-1:0]  shadow_q [NUM_WORDS];

  // VS synchronizer and falling-edge detect. A fall is only honoured once VS has
  // been seen high after reset, so releasing reset with VS low cannot start a frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      vs_dly_q   <= 1'b1;
      post_rst_q <= 1'b0;
      armed_q    <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      vs_meta_q  <= VGA_VS;
      vs_sync_q  <= vs_meta_q;
      vs_dly_q   <= vs_sync_q;
      post_rst_q <= 1'b1;
      armed_q    <= armed_q | (post_rst_q & vs_meta_q);
      trig_q     <= armed_q & vs_dly_q & ~vs_sync_q;
    end
  end

  // Next-state logic: one read outstanding, per-word timeout in WAIT_DATA.
  always_comb begin
    state_nx  = state_q;
    idx_nx    = idx_q;
    tmo_nx    = tmo_q;
    shadow_we = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_q && ENABLE) begin
          state_nx = REQ;
          idx_nx   = '0;
          tmo_nx   = '0;
        end
      end
      REQ: begin
        if (!AVL_M_WAITREQUEST) begin
          state_nx = WAIT_DATA;
          tmo_nx   = '0;
        end
      end
      WAIT_DATA: begin
        if (AVL_M_READDATAVALID) begin
          shadow_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_nx = COMMIT;
          end else begin
            idx_nx   = idx_q + 1'b1;
            state_nx = REQ;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_nx = IDLE;
          err_set  = 1'b1;
        end else begin
          tmo_nx = tmo_q + 1'b1;
        end
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and bus/status outputs, all derived from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      tmo_q         <= '0;
      AVL_M_READ    <= 1'b0;
      AVL_M_BYTE_EN <= 4'h0;
      AVL_M_ADDR    <= BASE_ADDR;
      FRAME_DONE    <= 1'b0;
      FETCH_ERR     <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      state_q       <= state_nx;
      idx_q         <= idx_nx;
      tmo_q         <= tmo_nx;
      AVL_M_READ    <= (state_nx == REQ);
      AVL_M_BYTE_EN <= (state_nx == REQ) ? 4'hF : 4'h0;
      AVL_M_ADDR    <= BASE_ADDR + 32'({idx_nx, 2'b00});
      FRAME_DONE    <= commit;
      BUSY          <= (state_nx != IDLE);
      if (commit) begin
        FETCH_ERR <= 1'b0;
      end else if (err_set) begin
        FETCH_ERR <= 1'b1;
      end
    end
  end

  // Shadow capture and snapshot commit; BODY_DATA only moves at COMMIT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        shadow_q[i] <= '0;
      end
      BODY_DATA <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        if (shadow_we && (idx_q == IDX_W'(i))) begin
          shadow_q[i] <= AVL_M_READDATA;
        end
      end
      if (commit) begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          BODY_DATA[i*WORD_W +: WORD_W] <= shadow_q[i];
        end
      end
    end
  end

endmodule
